// File: rtl/trng_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : trng_sampler
//  Description : Ring-oscillator entropy consumer. Synchronises and decimates
//                the raw oscillator stream, removes bias with a von Neumann
//                corrector, packs bits into WIDTH-bit words on a valid/ready
//                port, and runs a repetition-count health test that shuts
//                the oscillator down on a stuck output.
//  Revision    : 1.0 - initial release
// ============================================================================
module trng_sampler #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int SETTLE    = 2,
    parameter int RCT_LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             ro_out,
    output logic             ro_activate,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             health_fail,
    output logic             overrun,
    input  logic             clear_fail
);

    localparam int c_div_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_set_w = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int c_run_w = $clog2(RCT_LIMIT + 1);
    localparam int c_bit_w = $clog2(WIDTH);

    localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(DIV - 1);
    localparam logic [c_set_w-1:0] c_settle_max = c_set_w'(SETTLE);
    localparam logic [c_run_w-1:0] c_run_limit  = c_run_w'(RCT_LIMIT);
    localparam logic [c_run_w-1:0] c_run_one    = c_run_w'(1);
    localparam logic [c_bit_w-1:0] c_bit_last   = c_bit_w'(WIDTH - 1);

    // Debias state encoding
    localparam logic [0:0] c_st_first  = 1'b0;
    localparam logic [0:0] c_st_second = 1'b1;

    logic               r_ro_activate;
    logic               r_sync1;
    logic               r_ro_sync;
    logic [c_div_w-1:0] r_div_cnt;
    logic [c_set_w-1:0] r_settle_cnt;
    logic [c_run_w-1:0] r_run_cnt;
    logic               r_prev;
    logic               r_health_fail;
    logic [0:0]         r_state;
    logic               r_bit_a;
    logic [WIDTH-2:0]   r_shift;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_data_valid;
    logic               r_overrun;

    logic               w_flush;
    logic               w_strobe;
    logic               w_settled;
    logic               w_sample_en;
    logic               w_same;
    logic [c_run_w-1:0] w_run_next;
    logic               w_trip;
    logic               w_emit;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_word_done;
    logic               w_load;
    logic               w_drop;
    logic               w_accept;

    // Everything downstream of the oscillator idles while it is off, and also
    // in the single cycle between a health trip and ro_activate falling.
    assign w_flush      = ~r_ro_activate | r_health_fail;
    assign w_strobe     = ~w_flush & (r_div_cnt == c_div_last);
    assign w_settled    = (r_settle_cnt == c_settle_max);
    assign w_sample_en  = w_strobe & w_settled;

    // A zero run count means no sample has been seen since the last restart.
    assign w_same       = (r_run_cnt != '0) & (r_ro_sync == r_prev);
    assign w_run_next   = w_same ? (r_run_cnt + c_run_one) : c_run_one;
    assign w_trip       = w_sample_en & (w_run_next == c_run_limit);

    // Only an unequal pair produces a bit, and that bit is the first sample.
    assign w_emit       = w_sample_en & (r_state == c_st_second) & (r_bit_a != r_ro_sync);
    assign w_shift_next = {r_shift, r_bit_a};
    assign w_word_done  = w_emit & (r_bit_cnt == c_bit_last);
    assign w_accept     = r_data_valid & data_ready;

    // A word finishing on the tripping strobe is suspect and is discarded.
    assign w_load       = w_word_done & ~w_trip & (~r_data_valid | data_ready);
    assign w_drop       = w_word_done & ~w_trip & r_data_valid & ~data_ready;

    assign ro_activate  = r_ro_activate;
    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign health_fail  = r_health_fail;
    assign overrun      = r_overrun;

    // Oscillator enable follows the request unless the health test has tripped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ro_activate <= 1'b0;
        else        r_ro_activate <= enable & ~r_health_fail;
    end

    // Two-flop synchroniser for the asynchronous oscillator output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_ro_sync <= 1'b0;
        end else begin
            r_sync1   <= ro_out;
            r_ro_sync <= r_sync1;
        end
    end

    // Decimation counter producing one sample strobe every DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_div_cnt <= '0;
        else if (w_flush)                r_div_cnt <= '0;
        else if (r_div_cnt == c_div_last) r_div_cnt <= '0;
        else                             r_div_cnt <= r_div_cnt + c_div_w'(1);
    end

    // Counts strobes thrown away while the oscillator settles after start-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_settle_cnt <= '0;
        else if (w_flush)                r_settle_cnt <= '0;
        else if (w_strobe && !w_settled) r_settle_cnt <= r_settle_cnt + c_set_w'(1);
    end

    // Repetition-count health test on the raw (pre-debias) samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt <= '0;
            r_prev    <= 1'b0;
        end else if (w_flush) begin
            r_run_cnt <= '0;
            r_prev    <= 1'b0;
        end else if (w_sample_en) begin
            r_run_cnt <= w_run_next;
            r_prev    <= r_ro_sync;
        end
    end

    // Sticky failure flag; a new trip takes priority over a clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_health_fail <= 1'b0;
        else if (w_trip)     r_health_fail <= 1'b1;
        else if (clear_fail) r_health_fail <= 1'b0;
    end

    // Von Neumann pair collector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_first;
            r_bit_a <= 1'b0;
        end else if (w_flush) begin
            r_state <= c_st_first;
            r_bit_a <= 1'b0;
        end else if (w_sample_en) begin
            case (r_state)
                c_st_first: begin
                    r_bit_a <= r_ro_sync;
                    r_state <= c_st_second;
                end
                default: begin
                    r_state <= c_st_first;
                end
            endcase
        end
    end

    // Shift debiased bits in at the LSB; partial words never leave this block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_flush) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_emit) begin
            if (w_word_done) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else begin
                r_shift   <= w_shift_next[WIDTH-2:0];
                r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
            end
        end
    end

    // Output word register and valid flag; a trip flushes the held word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else if (w_trip) begin
            r_data_valid <= 1'b0;
        end else if (w_load) begin
            r_data_out   <= w_shift_next;
            r_data_valid <= 1'b1;
        end else if (w_accept) begin
            r_data_valid <= 1'b0;
        end
    end

    // Sticky flag for a completed word lost to a full output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_overrun <= 1'b0;
        else if (w_drop)     r_overrun <= 1'b1;
        else if (clear_fail) r_overrun <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_trng_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trng_sampler
//  Description : Self-checking bench for trng_sampler. Raw bits are driven
//                in step with the sample strobe; a small debias/pack model
//                queues expected words which are checked on each transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trng_sampler;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             ro_out;
    logic             ro_activate;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             health_fail;
    logic             overrun;
    logic             clear_fail;

    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mdl_bits;
    int               mdl_cnt;

    trng_sampler #(
        .WIDTH     (WIDTH),
        .DIV       (DIV),
        .SETTLE    (2),
        .RCT_LIMIT (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .ro_out      (ro_out),
        .ro_activate (ro_activate),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .health_fail (health_fail),
        .overrun     (overrun),
        .clear_fail  (clear_fail)
    );

    always #5 clk = ~clk;

    // Hold one raw bit for a full strobe period; returns just after the strobe edge
    task automatic drive_bit(input logic b);
        ro_out = b;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mdl_bits = '0;
        mdl_cnt  = 0;
    endtask

    // Drive one raw pair and update the expected-word model
    task automatic send_pair(input logic a, input logic b);
        drive_bit(a);
        drive_bit(b);
        if (a != b) begin
            mdl_bits = {mdl_bits[WIDTH-2:0], a};
            mdl_cnt++;
            if (mdl_cnt == WIDTH) begin
                exp_q.push_back(mdl_bits);
                mdl_cnt = 0;
            end
        end
    endtask

    // Raise enable, align to the oscillator start and feed the settle strobes
    task automatic start_stream(input logic s0, input logic s1);
        int t;
        enable = 1'b1;
        t = 0;
        while (ro_activate !== 1'b1 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_vec++;
        if (ro_activate !== 1'b1) begin
            n_err++;
            $display("FAIL start_stream: ro_activate=%b required 1 within 20 cycles", ro_activate);
        end
        drive_bit(s0);
        drive_bit(s1);
        model_clear();
    endtask

    task automatic stop_stream();
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Wait for a handshake, check the word against the scoreboard head
    task automatic expect_transfer(input string name);
        int t;
        logic [WIDTH-1:0] exp;
        t = 0;
        @(negedge clk);
        while (!(data_valid === 1'b1 && data_ready === 1'b1) && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (!(data_valid === 1'b1 && data_ready === 1'b1)) begin
            n_err++;
            $display("FAIL %s_timeout: data_valid=%b required 1 within 60 cycles", name, data_valid);
        end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_unexpected: data_out=%h while no word expected", name, data_out);
        end else begin
            exp = exp_q.pop_front();
            if (data_out !== exp) begin
                n_err++;
                $display("FAIL %s_word: data_out=%h required %h", name, data_out, exp);
            end
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_valid_clear: data_valid=%b required 0", name, data_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; ro_out = 1'b0; data_ready = 1'b1; clear_fail = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ro_activate !== 1'b0) begin n_err++; $display("FAIL rst_ro_activate: got %b required 0", ro_activate); end
        n_vec++; if (data_out !== '0)      begin n_err++; $display("FAIL rst_data_out: got %h required 00", data_out); end
        n_vec++; if (data_valid !== 1'b0)  begin n_err++; $display("FAIL rst_data_valid: got %b required 0", data_valid); end
        n_vec++; if (health_fail !== 1'b0) begin n_err++; $display("FAIL rst_health_fail: got %b required 0", health_fail); end
        n_vec++; if (overrun !== 1'b0)     begin n_err++; $display("FAIL rst_overrun: got %b required 0", overrun); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pairs_10();
        data_ready = 1'b1;
        start_stream(1'b0, 1'b0);
        repeat (8) send_pair(1'b1, 1'b0);
        expect_transfer("pairs10");
        stop_stream();
    endtask

    task automatic test_pairs_01();
        start_stream(1'b0, 1'b0);
        repeat (8) send_pair(1'b0, 1'b1);
        expect_transfer("pairs01");
        stop_stream();
    endtask

    task automatic test_alternating();
        start_stream(1'b0, 1'b0);
        repeat (4) begin
            send_pair(1'b1, 1'b0);
            send_pair(1'b0, 1'b1);
        end
        expect_transfer("alternating");
        stop_stream();
    endtask

    task automatic test_discard_pairs();
        start_stream(1'b0, 1'b0);
        repeat (3) begin
            send_pair(1'b1, 1'b0);
            send_pair(1'b0, 1'b0);
            send_pair(1'b1, 1'b0);
            send_pair(1'b1, 1'b1);
        end
        send_pair(1'b1, 1'b0);
        send_pair(1'b0, 1'b0);
        send_pair(1'b1, 1'b1);
        n_vec++;
        if (data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL discard_early: data_valid=%b required 0 after 7 contributing pairs", data_valid);
        end
        send_pair(1'b1, 1'b0);
        expect_transfer("discard");
        repeat (8) @(posedge clk);
        #1;
        n_vec++;
        if (data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL discard_extra_word: data_valid=%b required 0", data_valid);
        end
        stop_stream();
    endtask

    task automatic test_backpressure();
        data_ready = 1'b0;
        start_stream(1'b0, 1'b0);
        repeat (4) begin
            send_pair(1'b1, 1'b0);
            send_pair(1'b0, 1'b1);
        end
        n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL bp_first_valid: got %b required 1", data_valid); end
        n_vec++; if (data_out !== 8'hAA)  begin n_err++; $display("FAIL bp_first_word: got %h required aa", data_out); end
        repeat (4) begin
            send_pair(1'b0, 1'b1);
            send_pair(1'b1, 1'b0);
        end
        void'(exp_q.pop_back());  // second word is dropped by the DUT
        n_vec++; if (data_out !== 8'hAA)  begin n_err++; $display("FAIL bp_held_word: got %h required aa", data_out); end
        n_vec++; if (overrun !== 1'b1)    begin n_err++; $display("FAIL bp_overrun: got %b required 1", overrun); end
        n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL bp_held_valid: got %b required 1", data_valid); end
        data_ready = 1'b1;
        expect_transfer("backpressure");
        stop_stream();
        clear_fail = 1'b1;
        @(posedge clk);
        #1;
        clear_fail = 1'b0;
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_overrun_clear: got %b required 0", overrun); end
    endtask

    task automatic test_stuck();
        data_ready = 1'b0;
        start_stream(1'b0, 1'b0);
        repeat (8) send_pair(1'b1, 1'b0);
        void'(exp_q.pop_back());  // held word will be flushed by the trip
        n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL stuck_held_valid: got %b required 1", data_valid); end
        repeat (31) drive_bit(1'b1);
        n_vec++; if (health_fail !== 1'b0) begin n_err++; $display("FAIL stuck_early_trip: health_fail=%b required 0 after 31 strobes", health_fail); end
        drive_bit(1'b1);
        n_vec++; if (health_fail !== 1'b1) begin n_err++; $display("FAIL stuck_trip: health_fail=%b required 1 on 32nd strobe", health_fail); end
        n_vec++; if (data_valid !== 1'b0)  begin n_err++; $display("FAIL stuck_flush: data_valid=%b required 0", data_valid); end
        @(posedge clk);
        #1;
        n_vec++; if (ro_activate !== 1'b0) begin n_err++; $display("FAIL stuck_ro_off: ro_activate=%b required 0", ro_activate); end
        data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear_fail = 1'b1;
        @(posedge clk);
        #1;
        clear_fail = 1'b0;
        n_vec++; if (health_fail !== 1'b0) begin n_err++; $display("FAIL stuck_clear: health_fail=%b required 0", health_fail); end
        // Settle strobes carry a 1,0 pair that must not contribute a bit
        start_stream(1'b1, 1'b0);
        repeat (8) send_pair(1'b0, 1'b1);
        expect_transfer("stuck_restart");
        stop_stream();
    endtask

    task automatic test_enable_drop();
        start_stream(1'b0, 1'b0);
        send_pair(1'b1, 1'b0);
        send_pair(1'b0, 1'b1);
        send_pair(1'b1, 1'b0);
        send_pair(1'b1, 1'b0);
        send_pair(1'b0, 1'b1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        n_vec++; if (ro_activate !== 1'b0) begin n_err++; $display("FAIL drop_ro_off: ro_activate=%b required 0", ro_activate); end
        repeat (10) @(posedge clk);
        #1;
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL drop_partial: data_valid=%b required 0", data_valid); end
        model_clear();
        start_stream(1'b0, 1'b0);
        send_pair(1'b0, 1'b1);
        send_pair(1'b0, 1'b1);
        send_pair(1'b1, 1'b0);
        send_pair(1'b1, 1'b0);
        send_pair(1'b0, 1'b1);
        send_pair(1'b1, 1'b0);
        send_pair(1'b0, 1'b1);
        send_pair(1'b1, 1'b0);
        expect_transfer("reenable");
        stop_stream();
    endtask

    task automatic test_reset_mid();
        data_ready = 1'b0;
        start_stream(1'b0, 1'b0);
        repeat (8) send_pair(1'b1, 1'b0);
        n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b required 1", data_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (ro_activate !== 1'b0) begin n_err++; $display("FAIL midrst_ro_activate: got %b required 0", ro_activate); end
        n_vec++; if (data_out !== '0)      begin n_err++; $display("FAIL midrst_data_out: got %h required 00", data_out); end
        n_vec++; if (data_valid !== 1'b0)  begin n_err++; $display("FAIL midrst_data_valid: got %b required 0", data_valid); end
        n_vec++; if (health_fail !== 1'b0) begin n_err++; $display("FAIL midrst_health_fail: got %b required 0", health_fail); end
        n_vec++; if (overrun !== 1'b0)     begin n_err++; $display("FAIL midrst_overrun: got %b required 0", overrun); end
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (ro_activate !== 1'b1) begin n_err++; $display("FAIL midrst_release: ro_activate=%b required 1", ro_activate); end
        data_ready = 1'b1;
        stop_stream();
    endtask

    initial begin
        test_reset();
        test_pairs_10();
        test_pairs_01();
        test_alternating();
        test_discard_pairs();
        test_backpressure();
        test_stuck();
        test_enable_drop();
        test_reset_mid();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_words: %0d expected words never transferred, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
